// File: rtl/clk_div_ctrl_if.sv
// Handshake/control bundle for clk_div_ctrl.
// The optional statistics signals exist only when CLK_DIV_CTRL_STATS_EN is defined.
interface clk_div_ctrl_if #(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic [WIDTH-1:0]   div_val;
    logic               div_load;
    logic               div_ack;
    logic               tick;
    logic               clk_div;
    logic               busy;
    logic               done;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [31:0]        tick_count;
    logic               ovf_sticky;
`endif

    modport master (
        output start, stop, burst_len, div_val, div_load,
        input  div_ack, tick, clk_div, busy, done
`ifdef CLK_DIV_CTRL_STATS_EN
        , input tick_count, ovf_sticky
`endif
    );

    modport slave (
        input  start, stop, burst_len, div_val, div_load,
        output div_ack, tick, clk_div, busy, done
`ifdef CLK_DIV_CTRL_STATS_EN
        , output tick_count, ovf_sticky
`endif
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the clock-divider path.
// Owns the active divisor, sequences start/stop and finite tick bursts, and
// swaps divisors only at period boundaries so no short/long period is produced.
// Optional feature macro: CLK_DIV_CTRL_STATS_EN adds tick_count / ovf_sticky.
module clk_div_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 3,
    parameter int BURST_W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_ctrl_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   div_n;
    logic [WIDTH-1:0]   div_shadow;
    logic [WIDTH-1:0]   cnt;
    logic               pending;
    logic [BURST_W-1:0] remaining;
    logic               tc;
    logic               last_tick;
    logic               go;

    // A divisor of 0 would never reach terminal count, so treat it as 1.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(1) : v;
    endfunction

    // remaining == 0 marks a continuous run; otherwise the tick that consumes
    // the last count ends the burst.
    assign tc        = (state == RUN) && (cnt == div_n - WIDTH'(1));
    assign last_tick = tc && (remaining == BURST_W'(1));
    assign go        = bus.start && !bus.stop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: stop always wins over start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (bus.stop || last_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore-style outputs decoded from state and the period counter
    always_comb begin
        bus.busy = (state == RUN);
        bus.tick = tc;
    end

    // Shadow divisor holds the latest request until a period boundary (last write wins)
    always_ff @(posedge clk) begin
        if (bus.div_load) div_shadow <= clamp_div(bus.div_val);
    end

    // Period counter, divided clock, burst accounting and divisor hand-over
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            div_n       <= WIDTH'(DEFAULT_DIV);
            pending     <= 1'b0;
            remaining   <= '0;
            bus.clk_div <= 1'b0;
            bus.done    <= 1'b0;
            bus.div_ack <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.div_ack <= 1'b0;
            if (state == IDLE) begin
                cnt         <= '0;
                bus.clk_div <= 1'b0;
                if (go) remaining <= bus.burst_len;
                if (bus.div_load) begin
                    div_n       <= clamp_div(bus.div_val);
                    bus.div_ack <= 1'b1;
                end
            end else if (bus.stop) begin
                // Abort: nothing may stay pending once the block goes idle
                cnt         <= '0;
                bus.clk_div <= 1'b0;
                if (bus.div_load) begin
                    div_n       <= clamp_div(bus.div_val);
                    pending     <= 1'b0;
                    bus.div_ack <= 1'b1;
                end else if (pending) begin
                    div_n       <= div_shadow;
                    pending     <= 1'b0;
                    bus.div_ack <= 1'b1;
                end
            end else if (tc) begin
                cnt         <= '0;
                bus.clk_div <= last_tick ? 1'b0 : ~bus.clk_div;
                if (remaining != '0) remaining <= remaining - BURST_W'(1);
                if (last_tick) bus.done <= 1'b1;
                if (bus.div_load) begin
                    div_n       <= clamp_div(bus.div_val);
                    pending     <= 1'b0;
                    bus.div_ack <= 1'b1;
                end else if (pending) begin
                    div_n       <= div_shadow;
                    pending     <= 1'b0;
                    bus.div_ack <= 1'b1;
                end
            end else begin
                cnt <= cnt + WIDTH'(1);
                if (bus.div_load) pending <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_CTRL_STATS_EN
    // Free-running tick statistics; the sticky flag records any wrap of the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tick_count <= '0;
            bus.ovf_sticky <= 1'b0;
        end else if (tc) begin
            bus.tick_count <= bus.tick_count + 32'd1;
            if (&bus.tick_count) bus.ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl (DEFAULT_DIV=3, 10 ns clock).
// Expected tick cycles, clk_div levels, div_ack and done cycles are queued when
// stimulus is applied and popped by a monitor when the DUT produces them.
module tb_clk_div_ctrl;

    localparam int WIDTH   = 16;
    localparam int BURST_W = 8;

    typedef struct {
        int cyc;
        bit cd;
    } tick_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    tick_exp_t tick_q[$];
    int        ack_q[$];
    int        done_q[$];

    clk_div_ctrl_if #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut_if ();

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(3), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_ticks(input int first, input int period, input int count);
        for (int i = 0; i < count; i++) begin
            tick_exp_t e;
            e.cyc = first + i * period;
            e.cd  = bit'(i & 1);
            tick_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int blen);
        dut_if.start     = 1'b1;
        dut_if.burst_len = BURST_W'(blen);
        step();
        dut_if.start     = 1'b0;
        dut_if.burst_len = '0;
    endtask

    task automatic pulse_stop();
        dut_if.stop = 1'b1;
        step();
        dut_if.stop = 1'b0;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_tick_left"}, tick_q.size(), 0);
        chk({tag, "_ack_left"},  ack_q.size(),  0);
        chk({tag, "_done_left"}, done_q.size(), 0);
    endtask

    // Monitor: sample mid-cycle and match every DUT event against the scoreboard
    always @(negedge clk) begin
        if (dut_if.tick === 1'b1) begin
            if (tick_q.size() == 0) chk("unexpected_tick", 1, 0);
            else begin
                tick_exp_t e;
                e = tick_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("clk_div_at_tick", dut_if.clk_div, e.cd);
            end
        end
        if (dut_if.div_ack === 1'b1) begin
            if (ack_q.size() == 0) chk("unexpected_div_ack", 1, 0);
            else chk("div_ack_cycle", cyc, ack_q.pop_front());
        end
        if (dut_if.done === 1'b1) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, done_q.pop_front());
        end
    end

    initial begin
        int c;
        dut_if.start     = 1'b0;
        dut_if.stop      = 1'b0;
        dut_if.burst_len = '0;
        dut_if.div_val   = '0;
        dut_if.div_load  = 1'b0;

        // Reset for two cycles, then check reset outputs
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_busy",    dut_if.busy,    0);
        chk("rst_tick",    dut_if.tick,    0);
        chk("rst_done",    dut_if.done,    0);
        chk("rst_div_ack", dut_if.div_ack, 0);
        chk("rst_clk_div", dut_if.clk_div, 0);

        // 1: continuous run with default divisor 3
        c = cyc;
        push_ticks(c + 3, 3, 6);
        pulse_start(0);
        chk("t1_busy_first_cycle", dut_if.busy, 1);
        wait_until(c + 19);
        pulse_stop();
        chk("t1_busy_after_stop", dut_if.busy, 0);
        chk("t1_clk_div_idle", dut_if.clk_div, 0);
        repeat (4) step();
        queues_empty("t1");

        // 2: finite burst of 4
        c = cyc;
        push_ticks(c + 3, 3, 4);
        done_q.push_back(c + 13);
        pulse_start(4);
        wait_until(c + 12);
        chk("t2_busy_last_tick", dut_if.busy, 1);
        step();
        chk("t2_busy_after_burst", dut_if.busy, 0);
        chk("t2_clk_div_after_burst", dut_if.clk_div, 0);
        repeat (4) step();
        queues_empty("t2");

        // 3: divisor change to 5 during RUN at cnt==0
        c = cyc;
        push_ticks(c + 3, 3, 2);
        push_ticks(c + 11, 5, 3);
        tick_q[2].cd = 1'b0;
        tick_q[3].cd = 1'b1;
        tick_q[4].cd = 1'b0;
        ack_q.push_back(c + 7);
        pulse_start(0);
        wait_until(c + 4);
        dut_if.div_val  = 16'd5;
        dut_if.div_load = 1'b1;
        step();
        dut_if.div_load = 1'b0;
        wait_until(c + 22);
        pulse_stop();
        repeat (4) step();
        queues_empty("t3");

        // 4: divisor 0 loaded in IDLE clamps to 1; stop on a tick cycle still ticks
        ack_q.push_back(cyc + 1);
        dut_if.div_val  = 16'd0;
        dut_if.div_load = 1'b1;
        step();
        dut_if.div_load = 1'b0;
        step();
        c = cyc;
        push_ticks(c + 1, 1, 6);
        pulse_start(0);
        wait_until(c + 6);
        pulse_stop();
        chk("t4_busy_after_stop", dut_if.busy, 0);
        repeat (3) step();
        queues_empty("t4");

        // 5: reset mid-run after a divisor change, then restart at the default divisor
        ack_q.push_back(cyc + 1);
        dut_if.div_val  = 16'd5;
        dut_if.div_load = 1'b1;
        step();
        dut_if.div_load = 1'b0;
        step();
        c = cyc;
        push_ticks(c + 5, 5, 1);
        pulse_start(0);
        wait_until(c + 7);
        rst = 1'b1;
        step();
        chk("t5_rst_busy",    dut_if.busy,    0);
        chk("t5_rst_tick",    dut_if.tick,    0);
        chk("t5_rst_clk_div", dut_if.clk_div, 0);
        chk("t5_rst_done",    dut_if.done,    0);
        chk("t5_rst_div_ack", dut_if.div_ack, 0);
        rst = 1'b0;
        step();
        c = cyc;
        push_ticks(c + 3, 3, 2);
        pulse_start(0);
        wait_until(c + 7);
        pulse_stop();
        repeat (3) step();
        queues_empty("t5");

        // 6: start+stop together stays idle; stop mid-burst gives no done
        dut_if.start     = 1'b1;
        dut_if.stop      = 1'b1;
        dut_if.burst_len = 8'd2;
        step();
        dut_if.start     = 1'b0;
        dut_if.stop      = 1'b0;
        dut_if.burst_len = '0;
        chk("t6_busy_start_stop", dut_if.busy, 0);
        repeat (5) step();
        c = cyc;
        push_ticks(c + 3, 3, 1);
        pulse_start(10);
        wait_until(c + 4);
        chk("t6_clk_div_running", dut_if.clk_div, 1);
        pulse_stop();
        chk("t6_busy_after_stop", dut_if.busy, 0);
        chk("t6_done_after_stop", dut_if.done, 0);
        chk("t6_clk_div_forced", dut_if.clk_div, 0);
        repeat (12) step();
        queues_empty("t6");

        // 7: repeated div_load while pending (last wins, one ack); start in RUN ignored
        c = cyc;
        push_ticks(c + 3, 3, 2);
        push_ticks(c + 10, 4, 2);
        ack_q.push_back(c + 7);
        pulse_start(0);
        wait_until(c + 4);
        dut_if.div_val  = 16'd7;
        dut_if.div_load = 1'b1;
        step();
        dut_if.div_val  = 16'd4;
        step();
        dut_if.div_load = 1'b0;
        wait_until(c + 8);
        pulse_start(1);
        wait_until(c + 15);
        pulse_stop();
        repeat (3) step();
        queues_empty("t7a");

        // 7b: stop while a divisor update is pending applies it on the stop edge
        c = cyc;
        push_ticks(c + 4, 4, 1);
        ack_q.push_back(c + 7);
        pulse_start(0);
        wait_until(c + 5);
        dut_if.div_val  = 16'd2;
        dut_if.div_load = 1'b1;
        step();
        dut_if.div_load = 1'b0;
        pulse_stop();
        repeat (2) step();
        c = cyc;
        push_ticks(c + 2, 2, 2);
        pulse_start(0);
        wait_until(c + 5);
        pulse_stop();
        repeat (3) step();
        queues_empty("t7b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
